m_proc12: RTL

Parametrised 5-stage in-order pipelined processor core (IF/ID/EX/MEM/WB) for the MIPS subset ADD, ADDI, LW, SW, BEQ, BNE and HALT. It generalises the previous core in three ways: configurable data width, configurable memory depth, and a selectable forwarding mode. It also adds a hardware interlock for load-use and branch-operand hazards, so programs need no hand-inserted NOPs except the single branch delay slot. Instruction and data memories sit outside the core on synchronous-read ports, which lets the same core drive the simulation top and the FPGA top.

---
 rtl/m_proc12_if.sv | 32 +++
 rtl/m_proc12.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/m_proc12_if.sv
// m_proc12 memory bus: instruction and data ports.
// Both memories are synchronous-read with one cycle of latency.
interface m_proc12_if #(
  parameter int DW  = 32,
  parameter int IAW = 12,
  parameter int DAW = 12
);
  logic [IAW-1:0] w_imem_addr;
  logic [31:0]    w_imem_data;
  logic [DAW-1:0] w_dmem_addr;
  logic           w_dmem_we;
  logic [DW-1:0]  w_dmem_wdata;
  logic [DW-1:0]  w_dmem_rdata;

  modport master (
    output w_imem_addr,
    input  w_imem_data,
    output w_dmem_addr,
    output w_dmem_we,
    output w_dmem_wdata,
    input  w_dmem_rdata
  );

  modport slave (
    input  w_imem_addr,
    output w_imem_data,
    input  w_dmem_addr,
    input  w_dmem_we,
    input  w_dmem_wdata,
    output w_dmem_rdata
  );
endinterface

// File: rtl/m_proc12.sv
// m_proc12: 5-stage in-order MIPS-subset core with interlocks
// and optional EX forwarding; branches resolve in ID, one delay slot.
module m_proc12 #(
  parameter int DW     = 32,
  parameter int IAW    = 12,
  parameter int DAW    = 12,
  parameter int FWD_EN = 1
) (
  input  logic          w_clk,
  input  logic          w_rst,
  m_proc12_if.master    bus,
  output logic [DW-1:0] r_rout,
  output logic          r_halt,
  output logic [31:0]   r_stalls
);
  localparam int PCW = IAW + 2;

  typedef struct packed {
    logic          wr;
    logic          lw;
    logic          sw;
    logic          halt;
    logic [4:0]    dst;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic          use_imm;
  } id_ex_t;

  typedef struct packed {
    logic          wr;
    logic          lw;
    logic          sw;
    logic          halt;
    logic [4:0]    dst;
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
  } ex_mem_t;

  typedef struct packed {
    logic          wr;
    logic          lw;
    logic          halt;
    logic [4:0]    dst;
    logic [DW-1:0] alu;
  } mem_wb_t;

  logic [PCW-1:0] pc, id_pc, br_tgt, br_off;
  logic           id_valid;
  id_ex_t         ex, ex_d;
  ex_mem_t        mem, mem_d;
  mem_wb_t        wb;
  logic [DW-1:0]  rf [32];

  logic [31:0]   ins;
  logic [5:0]    op;
  logic [4:0]    rs, rt, rd, id_dst;
  logic [DW-1:0] id_imm, rs_v, rt_v, br_a, br_b;
  logic          d_add, d_addi, d_lw, d_sw, d_beq, d_bne, d_halt;
  logic          rd_rs, rd_rt, d_br, id_wr;
  logic          ex_hit, mem_hit, stall, taken;
  logic [DW-1:0] wb_val, fa, fb, alu;
  logic          wb_we;

  assign ins    = bus.w_imem_data;
  assign op     = ins[31:26];
  assign rs     = ins[25:21];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];
  assign id_imm = {{(DW-16){ins[15]}}, ins[15:0]};

  always_comb begin
    {d_add, d_addi, d_lw, d_sw, d_beq, d_bne, d_halt} = '0;
    if (id_valid) begin
      unique case (op)
        6'h00:   d_add  = 1'b1;
        6'h08:   d_addi = 1'b1;
        6'h23:   d_lw   = 1'b1;
        6'h2b:   d_sw   = 1'b1;
        6'h04:   d_beq  = 1'b1;
        6'h05:   d_bne  = 1'b1;
        6'h11:   d_halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign d_br   = d_beq | d_bne;
  assign rd_rs  = d_add | d_addi | d_lw | d_sw | d_br;
  assign rd_rt  = d_add | d_sw | d_br;
  assign id_dst = d_add ? rd : rt;
  // $0 destinations never count as writes, so hazards ignore them
  assign id_wr  = (d_add | d_addi | d_lw) && (id_dst != 5'd0);

  assign wb_val = wb.lw ? bus.w_dmem_rdata : wb.alu;
  assign wb_we  = wb.wr && !r_halt && !w_rst;

  always_comb begin
    rs_v = (rs == 5'd0) ? '0 : rf[rs];
    rt_v = (rt == 5'd0) ? '0 : rf[rt];
    if (wb_we && wb.dst == rs) rs_v = wb_val;
    if (wb_we && wb.dst == rt) rt_v = wb_val;
    br_a = rs_v;
    br_b = rt_v;
    if (FWD_EN != 0 && mem.wr && !mem.lw) begin
      if (mem.dst == rs) br_a = mem.alu;
      if (mem.dst == rt) br_b = mem.alu;
    end
  end

  assign ex_hit  = ex.wr &&
                   ((rd_rs && rs == ex.dst) || (rd_rt && rt == ex.dst));
  assign mem_hit = mem.wr &&
                   ((rd_rs && rs == mem.dst) || (rd_rt && rt == mem.dst));

  assign stall = !r_halt && (
                   (ex_hit && ex.lw) ||
                   (d_br && (ex_hit || (mem_hit && mem.lw))) ||
                   (FWD_EN == 0 && (ex_hit || mem_hit)));

  assign taken  = !stall && ((d_beq && br_a == br_b) ||
                             (d_bne && br_a != br_b));
  assign br_off = PCW'(id_imm << 2);
  assign br_tgt = id_pc + PCW'(4) + br_off;

  // while stalled, refetch the ID word so it is still there next cycle
  assign bus.w_imem_addr = stall ? id_pc[PCW-1:2] : pc[PCW-1:2];

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      pc       <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (!r_halt && !stall) begin
      pc       <= taken ? br_tgt : pc + PCW'(4);
      id_pc    <= pc;
      id_valid <= 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.wr      = id_wr;
      ex_d.lw      = d_lw;
      ex_d.sw      = d_sw;
      ex_d.halt    = d_halt;
      ex_d.dst     = id_dst;
      ex_d.rs      = rs;
      ex_d.rt      = rt;
      ex_d.a       = rs_v;
      ex_d.b       = rt_v;
      ex_d.imm     = id_imm;
      ex_d.use_imm = d_addi | d_lw | d_sw;
    end
  end

  always_comb begin
    fa = ex.a;
    fb = ex.b;
    if (FWD_EN != 0) begin
      if (mem.wr && !mem.lw && mem.dst == ex.rs) fa = mem.alu;
      else if (wb.wr && wb.dst == ex.rs)         fa = wb_val;
      if (mem.wr && !mem.lw && mem.dst == ex.rt) fb = mem.alu;
      else if (wb.wr && wb.dst == ex.rt)         fb = wb_val;
    end
    alu = fa + (ex.use_imm ? ex.imm : fb);
    mem_d      = '0;
    mem_d.wr   = ex.wr;
    mem_d.lw   = ex.lw;
    mem_d.sw   = ex.sw;
    mem_d.halt = ex.halt;
    mem_d.dst  = ex.dst;
    mem_d.alu  = alu;
    mem_d.sd   = fb;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!r_halt) begin
      ex  <= ex_d;
      mem <= mem_d;
      wb  <= '{wr: mem.wr, lw: mem.lw, halt: mem.halt,
               dst: mem.dst, alu: mem.alu};
    end
  end

  assign bus.w_dmem_addr  = mem.alu[DAW+1:2];
  assign bus.w_dmem_we    = mem.sw && !r_halt && !w_rst;
  assign bus.w_dmem_wdata = mem.sd;

  always_ff @(posedge w_clk) begin
    if (wb_we) rf[wb.dst] <= wb_val;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_rout   <= '0;
      r_halt   <= 1'b0;
      r_stalls <= '0;
    end else begin
      if (wb_we && wb.dst == 5'd30) r_rout <= wb_val;
      if (!r_halt && wb.halt)       r_halt <= 1'b1;
      if (stall && r_stalls != '1)  r_stalls <= r_stalls + 32'd1;
    end
  end
endmodule
